// File: rtl/nv_nvdla_rubik_rd_req_gen.sv
// nv_nvdla_rubik_rd_req_gen: splits a read command into 256-byte-bounded DMA requests gated by latency-FIFO credits
module nv_nvdla_rubik_rd_req_gen #(
  parameter int LAT_FIFO_DEPTH = 256
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [78:0] cmd_pd,
  output logic        rd_req_vld,
  input  logic        rd_req_rdy,
  output logic [78:0] rd_req_pd,
  input  logic        rd_cdt_lat_fifo_pop,
  output logic        op_done,
  output logic        credit_err
);
  localparam int CW = $clog2(LAT_FIFO_DEPTH) + 1;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nxt;
  logic [63:0] cur_addr;
  logic [15:0] remain;
  logic [CW-1:0] credit_cnt;
  logic [CW:0] credit_nxt;
  logic [3:0] room, k, beats;
  logic accept, last;
  assign room = 4'd8 - {1'b0, cur_addr[7:5]};
  assign k = (remain < {12'd0, room}) ? remain[3:0] : room;
  // 64-byte response beats touched: an odd start atom adds one partial beat
  assign beats = ({3'd0, cur_addr[5]} + k + 4'd1) >> 1;
  assign accept = rd_req_vld & rd_req_rdy;
  assign last = remain == {12'd0, k};
  assign credit_nxt = {1'b0, credit_cnt} - (accept ? (CW+1)'(beats) : '0) + (CW+1)'(rd_cdt_lat_fifo_pop);
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst)
    if (nvdla_core_rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (cmd_vld ? ISSUE : IDLE) : ((accept & last) ? IDLE : ISSUE);
  always_comb begin
    cmd_rdy = state == IDLE;
    rd_req_vld = (state == ISSUE) & ({1'b0, credit_cnt} >= (CW+1)'(beats));
    rd_req_pd = (state == ISSUE) ? {11'd0, k - 4'd1, cur_addr} : '0;
  end
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      cur_addr <= '0;
      remain <= '0;
      credit_cnt <= CW'(LAT_FIFO_DEPTH);
      op_done <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      if (state == IDLE && cmd_vld) begin
        cur_addr <= cmd_pd[63:0] & ~64'h1f;
        remain <= {1'b0, cmd_pd[78:64]} + 16'd1;
      end else if (accept) begin
        cur_addr <= cur_addr + {55'd0, k, 5'd0};
        remain <= remain - {12'd0, k};
      end
      op_done <= accept & last;
      if (credit_nxt > (CW+1)'(LAT_FIFO_DEPTH)) begin
        credit_cnt <= CW'(LAT_FIFO_DEPTH);
        credit_err <= 1'b1;
      end else begin
        credit_cnt <= credit_nxt[CW-1:0];
      end
    end
  end
endmodule

// File: tb/tb_nv_nvdla_rubik_rd_req_gen.sv
// tb_nv_nvdla_rubik_rd_req_gen: scoreboard bench for the rubik read-request generator
module tb_nv_nvdla_rubik_rd_req_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, cmd_vld, cmd_rdy, rd_req_vld, rd_req_rdy, pop, op_done, credit_err;
  logic [78:0] cmd_pd, rd_req_pd;
  logic cmd_vld4, cmd_rdy4, vld4, rdy4, pop4, done4, err4;
  logic [78:0] cmd_pd4, pd4;
  nv_nvdla_rubik_rd_req_gen dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_pd(cmd_pd),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_pd(rd_req_pd),
    .rd_cdt_lat_fifo_pop(pop), .op_done(op_done), .credit_err(credit_err));
  nv_nvdla_rubik_rd_req_gen #(.LAT_FIFO_DEPTH(4)) dut4 (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .cmd_vld(cmd_vld4), .cmd_rdy(cmd_rdy4), .cmd_pd(cmd_pd4),
    .rd_req_vld(vld4), .rd_req_rdy(rdy4), .rd_req_pd(pd4),
    .rd_cdt_lat_fifo_pop(pop4), .op_done(done4), .credit_err(err4));
  typedef struct {logic [78:0] pd; int beats;} exp_t;
  exp_t q[$];
  int exp_cr, errors, checks;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // reference split: walk to each 256-byte boundary, count 64-byte lines touched
  task automatic model_push(input logic [63:0] addr, input int n);
    logic [63:0] a;
    int r, room, k;
    exp_t e;
    a = addr & ~64'h1f;
    r = n;
    while (r > 0) begin
      room = (256 - int'(a[7:0])) / 32;
      k = (r < room) ? r : room;
      e.pd = {15'(k - 1), a};
      e.beats = int'(((a + 64'(k * 32) - 64'd1) >> 6) - (a >> 6)) + 1;
      q.push_back(e);
      a = a + 64'(k * 32);
      r = r - k;
    end
  endtask
  task automatic restore_credits();
    pop = 1'b1;
    while (exp_cr < 256) begin
      step();
      exp_cr++;
    end
    pop = 1'b0;
  endtask
  task automatic test_cmd(input logic [63:0] addr, input int n);
    model_push(addr, n);
    cmd_pd = {15'(n - 1), addr};
    cmd_vld = 1'b1;
    rd_req_rdy = 1'b1;
    if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL cmd_rdy_idle: got %b want 1", cmd_rdy); end checks++;
    step();
    cmd_vld = 1'b0;
    if (op_done !== 1'b0) begin errors++; $display("FAIL op_done_early: got %b want 0", op_done); end checks++;
    while (q.size() > 0) begin
      if (rd_req_vld !== 1'b1) begin errors++; $display("FAIL req_vld: got %b want 1", rd_req_vld); end checks++;
      if (rd_req_pd !== q[0].pd) begin errors++; $display("FAIL req_pd: got %h want %h", rd_req_pd, q[0].pd); end checks++;
      if (dut.credit_cnt !== exp_cr) begin errors++; $display("FAIL req_credit: got %0d want %0d", dut.credit_cnt, exp_cr); end checks++;
      exp_cr -= q[0].beats;
      void'(q.pop_front());
      step();
    end
    if (op_done !== 1'b1) begin errors++; $display("FAIL op_done: got %b want 1", op_done); end checks++;
    if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL cmd_rdy_done: got %b want 1", cmd_rdy); end checks++;
    if (rd_req_vld !== 1'b0) begin errors++; $display("FAIL vld_done: got %b want 0", rd_req_vld); end checks++;
    if (dut.credit_cnt !== exp_cr) begin errors++; $display("FAIL credit_done: got %0d want %0d", dut.credit_cnt, exp_cr); end checks++;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL rst_cmd_rdy: got %b want 1", cmd_rdy); end checks++;
    if (rd_req_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b want 0", rd_req_vld); end checks++;
    if (rd_req_pd !== 79'd0) begin errors++; $display("FAIL rst_pd: got %h want 0", rd_req_pd); end checks++;
    if (op_done !== 1'b0) begin errors++; $display("FAIL rst_op_done: got %b want 0", op_done); end checks++;
    if (credit_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", credit_err); end checks++;
    if (dut.credit_cnt !== 256) begin errors++; $display("FAIL rst_credit: got %0d want 256", dut.credit_cnt); end checks++;
    if (dut4.credit_cnt !== 4) begin errors++; $display("FAIL rst_credit4: got %0d want 4", dut4.credit_cnt); end checks++;
    rst = 1'b0;
    step();
  endtask
  task automatic test_unaligned_split();
    test_cmd(64'h1000_0060, 10);
    if (dut.credit_cnt !== 250) begin errors++; $display("FAIL split_credit: got %0d want 250", dut.credit_cnt); end checks++;
    restore_credits();
  endtask
  task automatic test_full_line();
    test_cmd(64'h0, 8);
    if (dut.credit_cnt !== 252) begin errors++; $display("FAIL line_credit: got %0d want 252", dut.credit_cnt); end checks++;
    pop = 1'b1;
    repeat (4) begin
      step();
      exp_cr++;
    end
    pop = 1'b0;
    if (dut.credit_cnt !== 256) begin errors++; $display("FAIL line_return: got %0d want 256", dut.credit_cnt); end checks++;
  endtask
  task automatic test_credit_stall();
    cmd_pd4 = {15'd15, 64'h0};
    cmd_vld4 = 1'b1;
    rdy4 = 1'b1;
    step();
    cmd_vld4 = 1'b0;
    if (vld4 !== 1'b1) begin errors++; $display("FAIL stall_first_vld: got %b want 1", vld4); end checks++;
    if (pd4 !== {15'd7, 64'h0}) begin errors++; $display("FAIL stall_first_pd: got %h want %h", pd4, {15'd7, 64'h0}); end checks++;
    step();
    if (dut4.credit_cnt !== 0) begin errors++; $display("FAIL stall_credit0: got %0d want 0", dut4.credit_cnt); end checks++;
    if (vld4 !== 1'b0) begin errors++; $display("FAIL stall_held: got %b want 0", vld4); end checks++;
    pop4 = 1'b1;
    repeat (3) begin
      step();
      if (vld4 !== 1'b0) begin errors++; $display("FAIL stall_partial: got %b want 0", vld4); end checks++;
    end
    step();
    pop4 = 1'b0;
    if (vld4 !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", vld4); end checks++;
    if (pd4 !== {15'd7, 64'h100}) begin errors++; $display("FAIL stall_pd: got %h want %h", pd4, {15'd7, 64'h100}); end checks++;
    if (dut4.credit_cnt !== 4) begin errors++; $display("FAIL stall_credit4: got %0d want 4", dut4.credit_cnt); end checks++;
    step();
    if (done4 !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done4); end checks++;
    if (dut4.credit_cnt !== 0) begin errors++; $display("FAIL stall_credit_end: got %0d want 0", dut4.credit_cnt); end checks++;
  endtask
  task automatic test_backpressure();
    model_push(64'ha0, 11);
    cmd_pd = {15'd10, 64'ha0};
    cmd_vld = 1'b1;
    rd_req_rdy = 1'b0;
    step();
    cmd_pd = {15'd3, 64'hdead_0000};
    repeat (5) begin
      if (rd_req_vld !== 1'b1) begin errors++; $display("FAIL bp_vld: got %b want 1", rd_req_vld); end checks++;
      if (rd_req_pd !== q[0].pd) begin errors++; $display("FAIL bp_pd: got %h want %h", rd_req_pd, q[0].pd); end checks++;
      if (dut.credit_cnt !== exp_cr) begin errors++; $display("FAIL bp_credit: got %0d want %0d", dut.credit_cnt, exp_cr); end checks++;
      step();
    end
    cmd_vld = 1'b0;
    rd_req_rdy = 1'b1;
    pop = 1'b1;
    if (rd_req_pd !== q[0].pd) begin errors++; $display("FAIL bp_pd_accept: got %h want %h", rd_req_pd, q[0].pd); end checks++;
    exp_cr = exp_cr - q[0].beats + 1;
    void'(q.pop_front());
    step();
    pop = 1'b0;
    if (dut.credit_cnt !== 255) begin errors++; $display("FAIL bp_net_credit: got %0d want 255", dut.credit_cnt); end checks++;
    if (rd_req_vld !== 1'b1) begin errors++; $display("FAIL bp_second_vld: got %b want 1", rd_req_vld); end checks++;
    if (rd_req_pd !== q[0].pd) begin errors++; $display("FAIL bp_second_pd: got %h want %h", rd_req_pd, q[0].pd); end checks++;
    exp_cr -= q[0].beats;
    void'(q.pop_front());
    step();
    if (op_done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", op_done); end checks++;
    if (dut.credit_cnt !== exp_cr) begin errors++; $display("FAIL bp_credit_end: got %0d want %0d", dut.credit_cnt, exp_cr); end checks++;
    step();
    if (rd_req_vld !== 1'b0) begin errors++; $display("FAIL bp_ignored_cmd: got %b want 0", rd_req_vld); end checks++;
    restore_credits();
  endtask
  task automatic test_back_to_back();
    test_cmd(64'h0000_1234_5678_9ac0, 40);
    test_cmd({$urandom, $urandom}, int'($urandom_range(1, 24)));
    test_cmd({$urandom, $urandom}, int'($urandom_range(1, 24)));
    restore_credits();
  endtask
  task automatic test_overflow();
    pop = 1'b1;
    step();
    pop = 1'b0;
    if (dut.credit_cnt !== 256) begin errors++; $display("FAIL ovf_credit: got %0d want 256", dut.credit_cnt); end checks++;
    if (credit_err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", credit_err); end checks++;
    repeat (3) step();
    if (credit_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", credit_err); end checks++;
  endtask
  task automatic test_reset_mid();
    model_push(64'h0, 32);
    cmd_pd = {15'd31, 64'h0};
    cmd_vld = 1'b1;
    rd_req_rdy = 1'b1;
    step();
    cmd_vld = 1'b0;
    if (rd_req_pd !== q[0].pd) begin errors++; $display("FAIL mid_pd0: got %h want %h", rd_req_pd, q[0].pd); end checks++;
    step();
    if (rd_req_pd !== q[1].pd) begin errors++; $display("FAIL mid_pd1: got %h want %h", rd_req_pd, q[1].pd); end checks++;
    if (dut.credit_cnt !== 252) begin errors++; $display("FAIL mid_credit: got %0d want 252", dut.credit_cnt); end checks++;
    #2;
    rst = 1'b1;
    #1;
    if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL mid_cmd_rdy: got %b want 1", cmd_rdy); end checks++;
    if (rd_req_vld !== 1'b0) begin errors++; $display("FAIL mid_vld: got %b want 0", rd_req_vld); end checks++;
    if (rd_req_pd !== 79'd0) begin errors++; $display("FAIL mid_pd: got %h want 0", rd_req_pd); end checks++;
    if (op_done !== 1'b0) begin errors++; $display("FAIL mid_op_done: got %b want 0", op_done); end checks++;
    if (credit_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", credit_err); end checks++;
    if (dut.credit_cnt !== 256) begin errors++; $display("FAIL mid_credit_rst: got %0d want 256", dut.credit_cnt); end checks++;
    step();
    rst = 1'b0;
    q.delete();
    exp_cr = 256;
    step();
    if (rd_req_vld !== 1'b0) begin errors++; $display("FAIL mid_after_vld: got %b want 0", rd_req_vld); end checks++;
    if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL mid_after_rdy: got %b want 1", cmd_rdy); end checks++;
  endtask
  task automatic test_wrap();
    test_cmd(64'hffff_ffff_ffff_ffe0, 2);
    if (dut.credit_cnt !== 254) begin errors++; $display("FAIL wrap_credit: got %0d want 254", dut.credit_cnt); end checks++;
  endtask
  initial begin
    errors = 0;
    checks = 0;
    exp_cr = 256;
    rst = 1'b0;
    cmd_vld = 1'b0;
    cmd_pd = '0;
    rd_req_rdy = 1'b0;
    pop = 1'b0;
    cmd_vld4 = 1'b0;
    cmd_pd4 = '0;
    rdy4 = 1'b0;
    pop4 = 1'b0;
    test_reset();
    test_unaligned_split();
    test_full_line();
    test_credit_stall();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
